// File: rtl/cqu_mips_pkg.sv
// cqu_mips_pkg: load size encodings, load-controller state enum and alignment helper.
package cqu_mips_pkg;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_RSVD = 2'd3} ld_size_e;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_RESP, S_ERR} ld_state_e;
   // Reserved size behaves as a word, so anything above half needs a 4-byte boundary.
   function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] lo);
      return (size == SZ_HALF) ? lo[0] : (size != SZ_BYTE) && (lo != 2'b00);
   endfunction
endpackage

// File: rtl/mem_load_ctrl_if.sv
// mem_load_ctrl_if: MEM-stage load port plus data-RAM read port of the load controller.
interface mem_load_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [1:0]        ld_size;
   logic              ld_signed;
   logic              flush;
   logic              dram_req;
   logic [ADDR_W-1:0] dram_addr;
   logic              dram_addr_ok;
   logic              dram_data_ok;
   logic [DATA_W-1:0] dram_rdata;
   logic              ld_done;
   logic [DATA_W-1:0] ld_data;
   logic              adel;
   logic [ADDR_W-1:0] badvaddr;
   logic              stall;
   modport master (
      input  ld_valid, ld_addr, ld_size, ld_signed, flush, dram_addr_ok, dram_data_ok, dram_rdata,
      output ld_ready, dram_req, dram_addr, ld_done, ld_data, adel, badvaddr, stall
   );
   modport slave (
      output ld_valid, ld_addr, ld_size, ld_signed, flush, dram_addr_ok, dram_data_ok, dram_rdata,
      input  ld_ready, dram_req, dram_addr, ld_done, ld_data, adel, badvaddr, stall
   );
endinterface

// File: rtl/extend.sv
// extend: widens a field to OUT_W bits, offering both sign- and zero-extended forms.
module extend #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] sext,
   output logic [OUT_W-1:0] zext
);
   assign sext = {{(OUT_W - IN_W){din[IN_W-1]}}, din};
   assign zext = {{(OUT_W - IN_W){1'b0}}, din};
endmodule

// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: sequences one data-RAM read per load, aligns/extends the result, flags misaligned loads.
module mem_load_ctrl
   import cqu_mips_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic           clk,
   input logic           resetn,
   mem_load_ctrl_if.master bus
);
   ld_state_e         state, nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              sgn_q;
   logic [DATA_W-1:0] data_q;
   logic              accept;
   logic [7:0]        b;
   logic [15:0]       h;
   logic [31:0]       b_sx, b_zx, h_sx, h_zx, ext;

   assign accept = bus.ld_valid & ~bus.flush;
   assign b = bus.dram_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign h = addr_q[1] ? bus.dram_rdata[31:16] : bus.dram_rdata[15:0];

   extend #(.IN_W(8),  .OUT_W(32)) u_ext_b (.din(b), .sext(b_sx), .zext(b_zx));
   extend #(.IN_W(16), .OUT_W(32)) u_ext_h (.din(h), .sext(h_sx), .zext(h_zx));

   assign ext = (size_q == SZ_BYTE) ? (sgn_q ? b_sx : b_zx) :
                (size_q == SZ_HALF) ? (sgn_q ? h_sx : h_zx) : bus.dram_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         addr_q <= '0;
         size_q <= '0;
         sgn_q  <= 1'b0;
         data_q <= '0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && accept) begin
            addr_q <= bus.ld_addr;
            size_q <= bus.ld_size;
            sgn_q  <= bus.ld_signed;
         end
         if (state == S_DATA && bus.dram_data_ok && !bus.flush) data_q <= ext;
      end
   end

   // A flush that coincides with addr_ok still owes us a data beat, so it must be drained.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (accept) nxt = ld_misaligned(bus.ld_size, bus.ld_addr[1:0]) ? S_ERR : S_ADDR;
         S_ADDR:  if (bus.flush) nxt = bus.dram_addr_ok ? S_DRAIN : S_IDLE;
                  else if (bus.dram_addr_ok) nxt = S_DATA;
         S_DATA:  if (bus.dram_data_ok) nxt = bus.flush ? S_IDLE : S_RESP;
                  else if (bus.flush) nxt = S_DRAIN;
         S_DRAIN: if (bus.dram_data_ok) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   assign bus.ld_ready  = state == S_IDLE;
   assign bus.dram_req  = state == S_ADDR;
   assign bus.dram_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.ld_done   = state == S_RESP;
   assign bus.ld_data   = data_q;
   assign bus.adel      = state == S_ERR;
   assign bus.badvaddr  = addr_q;
   assign bus.stall     = (state == S_IDLE && accept) || state inside {S_ADDR, S_DATA, S_DRAIN};
endmodule

// File: doc/mem_load_ctrl.md
MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width; only 32 supported.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 ld_valid  input  1  MEM stage presents a load.
REQ-006 ld_ready  output  1  controller can accept a load (state IDLE).
REQ-007 ld_addr  input  ADDR_W  byte address of load.
REQ-008 ld_size  input  2  0=byte, 1=half, 2=word; 3 reserved, treated as word.
REQ-009 ld_signed  input  1  1=sign-extend (LB/LH), 0=zero-extend (LBU/LHU).
REQ-010 flush  input  1  pipeline flush; abandons the current load.
REQ-011 dram_req  output  1  data-RAM read request.
REQ-012 dram_addr  output  ADDR_W  word-aligned request address ({addr[31:2],2'b00}).
REQ-013 dram_addr_ok  input  1  RAM accepted request this cycle.
REQ-014 dram_data_ok  input  1  RAM returns read data this cycle.
REQ-015 dram_rdata  input  DATA_W  RAM read data.
REQ-016 ld_done  output  1  one-cycle pulse; ld_data valid.
REQ-017 ld_data  output  DATA_W  aligned, extended load result.
REQ-018 adel  output  1  one-cycle pulse; address-error-on-load.
REQ-019 badvaddr  output  ADDR_W  faulting address, valid with adel.
REQ-020 stall  output  1  hold upstream pipeline.

Function
REQ-021 FSM states IDLE, ADDR, DATA, DRAIN, RESP, ERR.
REQ-022 IDLE: accept when ld_valid & !flush; latch addr/size/signed; misaligned (half & addr[0], word & addr[1:0]!=0) -> ERR, else -> ADDR.
REQ-023 ADDR: dram_req=1, dram_addr held; dram_addr_ok -> DATA; flush before addr_ok -> IDLE, request withdrawn next cycle.
REQ-024 DATA: dram_data_ok -> RESP, capture extracted result into ld_data register; flush -> DRAIN (flush with data_ok in same cycle -> IDLE, data discarded).
REQ-025 DRAIN: wait dram_data_ok, discard data, -> IDLE; no ld_done.
REQ-026 RESP: ld_done=1 one cycle -> IDLE; ld_data holds value until next capture.
REQ-027 ERR: adel=1, badvaddr=latched addr one cycle -> IDLE; no RAM request issued.
REQ-028 dram_data_ok sampled only in DATA/DRAIN; ignored elsewhere; RAM guarantees data_ok no earlier than cycle after addr_ok.
REQ-029 Minimum latency: accept cycle N, dram_req from N+1, addr_ok at N+1, data_ok at N+2, ld_done at N+3.
REQ-030 Extraction: byte = dram_rdata[8*addr[1:0]+7 -: 8]; half = addr[1] ? [31:16] : [15:0]; word = full 32 bits.
REQ-031 Byte/half extended to 32 bits per ld_signed; word unmodified.
REQ-032 stall = (IDLE & ld_valid & !flush) | state in {ADDR, DATA, DRAIN}; low in RESP and ERR.
REQ-033 ld_ready = (state == IDLE); new load not accepted in RESP (one-cycle bubble).
REQ-034 flush in RESP or ERR does not suppress ld_done/adel.

Reset
REQ-035 resetn low: state IDLE; dram_req, ld_done, adel, stall=0; ld_data, badvaddr, dram_addr=0; ld_ready=1 after release.
REQ-036 Reset mid-transaction abandons it; a RAM data_ok arriving after reset is ignored in IDLE.

Structure
REQ-037 Size encodings and FSM state enum in shared package cqu_mips_pkg.
REQ-038 Two instances of existing extend sub-module (8->32, 16->32), IS_SIGNAL chosen per ld_signed via mux on outputs.

Verification
REQ-039 LB addr 0x103, rdata 0x80FF_1234, signed -> ld_done at N+3, ld_data 0xFFFF_FF80.
REQ-040 LHU addr 0x202, rdata 0x8001_7FFF -> ld_data 0x0000_8001; dram_addr 0x200.
REQ-041 LW addr 0x301 -> adel pulse at N+1, badvaddr 0x301, dram_req never high, no ld_done.
REQ-042 LW addr 0x400, addr_ok delayed 3 cycles, data_ok 2 after -> stall high throughout, single ld_done, ld_data == rdata.
REQ-043 flush in DATA, data_ok 2 cycles later -> DRAIN, no ld_done, ld_ready high cycle after data_ok.
REQ-044 resetn low during ADDR -> dram_req 0 immediately, all outputs reset values.
